// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-port unified memory between the CPU and a DMA/loader port.
// Define ARB_STARVE_GUARD_EN to force a DMA grant after MAX_CPU_STREAK consecutive CPU wins.
module mem_arbiter #(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA, S_DMA_LOCK} state_t;

    state_t state_q, state_d;
    logic   cpu_rvalid_q, dma_rvalid_q;
    logic   guard_fire, dma_win, cpu_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);
    logic [3:0] streak_q, streak_d;

    // Counts CPU wins over a waiting DMA; any cycle without a waiting DMA restarts it.
    always_comb
        streak_d = (cpu_win && dma_req) ? ((streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1) : 4'd0;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) streak_q <= 4'd0;
        else          streak_q <= streak_d;

    assign guard_fire = (streak_q == STREAK_MAX);
`else
    assign guard_fire = 1'b0;
`endif

    assign dma_win = dma_req && ((state_q == S_DMA_LOCK) || !cpu_req || guard_fire);
    assign cpu_win = cpu_req && !dma_win;

    always_comb begin
        state_d = S_IDLE;
        if (dma_win)      state_d = dma_lock ? S_DMA_LOCK : S_DMA;
        else if (cpu_win) state_d = S_CPU;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= cpu_win && !cpu_we;
            dma_rvalid_q <= dma_win && !dma_we;
        end
    end

    always_comb begin
        cpu_gnt   = cpu_win;
        dma_gnt   = dma_win;
        owner     = {dma_win, cpu_win};
        mem_en    = cpu_win || dma_win;
        mem_we    = dma_win ? dma_we    : (cpu_win ? cpu_we    : 1'b0);
        mem_addr  = dma_win ? dma_addr  : (cpu_win ? cpu_addr  : 16'h0000);
        mem_wdata = dma_win ? dma_wdata : (cpu_win ? cpu_wdata : 16'h0000);
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign rdata      = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand sequences and random traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        bit          cr, cw;
        logic [15:0] ca, cd;
        bit          dr, dw;
        logic [15:0] da, dd;
        bit          dl;
        logic [1:0]  own;
        bit          crv, drv;
        logic [15:0] rd;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  owner;

    bit [15:0] env_mem [65536];
    bit        env_wr  [65536];
    bit [15:0] sh_mem  [65536];
    bit        sh_wr   [65536];

    int          n_cmp = 0, n_bad = 0;
    bit          m_lock, m_crv, m_drv, m_cw, m_dw;
    int          m_streak;
    logic [15:0] m_rd;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_CPU_STREAK(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [15:0] dflt(logic [15:0] a);
        return 16'h1000 + a * 16'd3;
    endfunction

    // Single-port synchronous memory: unwritten words read back as dflt(addr).
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) begin
                env_mem[mem_addr] <= mem_wdata;
                env_wr[mem_addr]  <= 1'b1;
            end else
                mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : dflt(mem_addr);
        end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    task automatic drive(bit cr, bit cw, logic [15:0] ca, logic [15:0] cd,
                         bit dr, bit dw, logic [15:0] da, logic [15:0] dd, bit dl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    endtask

    task automatic model_reset();
        m_lock = 1'b0; m_streak = 0; m_crv = 1'b0; m_drv = 1'b0;
    endtask

    // Checks this cycle's outputs against the arbitration rules, then books the transaction.
    task automatic model_check(string tag);
        bit          dw, cw, we;
        logic [15:0] a, wd;
        dw = dma_req && (m_lock || !cpu_req || (GUARD && m_streak >= MAX));
        cw = cpu_req && !dw;
        we = dw ? dma_we : (cw ? cpu_we : 1'b0);
        a  = dw ? dma_addr : (cw ? cpu_addr : 16'h0);
        wd = dw ? dma_wdata : (cw ? cpu_wdata : 16'h0);
        chk({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'(cw));
        chk({tag, ".dma_gnt"},    32'(dma_gnt),    32'(dw));
        chk({tag, ".owner"},      32'(owner),      32'({dw, cw}));
        chk({tag, ".mem_en"},     32'(mem_en),     32'(cw || dw));
        chk({tag, ".mem_we"},     32'(mem_we),     32'(we));
        chk({tag, ".mem_addr"},   32'(mem_addr),   32'(a));
        chk({tag, ".mem_wdata"},  32'(mem_wdata),  32'(wd));
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(m_crv));
        chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(m_drv));
        if (m_crv || m_drv) chk({tag, ".rdata"}, 32'(rdata), 32'(m_rd));
        m_crv = cw && !cpu_we;
        m_drv = dw && !dma_we;
        if ((cw || dw) && !we) m_rd = sh_wr[a] ? sh_mem[a] : dflt(a);
        if (we) begin
            sh_mem[a] = wd;
            sh_wr[a]  = 1'b1;
        end
        m_lock   = dw && dma_lock;
        m_streak = (cw && dma_req) ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
        m_cw = cw;
        m_dw = dw;
    endtask

    initial begin
        vec_t        tbl [12];
        bit          cr, cw, dr, dw, dl;
        logic [15:0] ca, cd, da, dd;
        //             cr cw ca       cd       dr dw da       dd       dl own    crv drv rd
        tbl[0]  = '{1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 0, 0, 16'h0000};
        tbl[1]  = '{1, 0, 16'h0001, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 0, 16'h1000};
        tbl[2]  = '{1, 0, 16'h0002, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 0, 16'h1003};
        tbl[3]  = '{1, 0, 16'h0003, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 1, 0, 16'h1006};
        tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 0, 2'b10, 1, 0, 16'h1009};
        tbl[5]  = '{1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 0, 0, 16'h0000};
        tbl[6]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 16'hBEEF};
        tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0050, 16'h1111, 1, 2'b10, 0, 0, 16'h0000};
        tbl[8]  = '{1, 0, 16'h0010, 16'h0000, 1, 1, 16'h0051, 16'h2222, 1, 2'b10, 0, 0, 16'h0000};
        tbl[9]  = '{1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0040, 16'h0000, 1, 2'b10, 0, 0, 16'h0000};
        tbl[10] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b01, 0, 1, 16'hBEEF};
        tbl[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 2'b00, 1, 0, 16'h1030};

        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        model_reset();
        #2;
        chk("rst.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst.dma_rvalid", 32'(dma_rvalid), 32'd0);
        model_check("rst");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].dl);
            #1;
            chk($sformatf("vec%0d.owner", i),      32'(owner),      32'(tbl[i].own));
            chk($sformatf("vec%0d.cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].crv));
            chk($sformatf("vec%0d.dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].drv));
            if (tbl[i].crv || tbl[i].drv) chk($sformatf("vec%0d.rdata", i), 32'(rdata), 32'(tbl[i].rd));
            model_check($sformatf("vec%0d", i));
        end

        // Both ports requesting continuously.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0, 0);
            #1;
            chk($sformatf("starve%0d.owner", i), 32'(owner), (GUARD && i % 5 == 4) ? 32'd2 : 32'd1);
            model_check($sformatf("starve%0d", i));
        end

        // Reset while the DMA holds the lock.
        @(negedge clk);
        drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0060, 16'h3333, 1);
        #1;
        chk("lock.owner", 32'(owner), 32'd2);
        model_check("lock");
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        model_reset();
        #1;
        chk("rst2.owner", 32'(owner), 32'd0);
        model_check("rst2");

        // Build a full CPU streak ending in a read, then reset right after that grant.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset_n = 1'b1;
            drive(1, 0, 16'h0007, 16'h0, 1, 0, 16'h0008, 16'h0, 1);
            #1;
            chk($sformatf("postrst%0d.owner", i), 32'(owner), 32'd1);
            model_check($sformatf("postrst%0d", i));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        model_reset();
        #1;
        chk("rst3.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst3.owner", 32'(owner), 32'd0);
        model_check("rst3");
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 16'h0007, 16'h0, 1, 0, 16'h0008, 16'h0, 0);
        #1;
        chk("rst3.after.owner", 32'(owner), 32'd1);
        chk("rst3.after.cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        model_check("rst3.after");

        // Random traffic; a requester keeps its request stable until granted.
        cr = 1'b0; dr = 1'b0;
        cw = 1'b0; dw = 1'b0; dl = 1'b0;
        ca = 16'h0; cd = 16'h0; da = 16'h0; dd = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if (!cr || m_cw) begin
                cr = $urandom_range(0, 3) != 0;
                cw = 1'($urandom_range(0, 1));
                ca = 16'($urandom_range(0, 31));
                cd = 16'($urandom);
            end
            if (!dr || m_dw) begin
                dr = $urandom_range(0, 2) != 0;
                dw = 1'($urandom_range(0, 1));
                da = 16'($urandom_range(0, 31));
                dd = 16'($urandom);
                dl = $urandom_range(0, 3) == 0;
            end
            @(negedge clk);
            drive(cr, cw, ca, cd, dr, dw, da, dd, dl);
            #1;
            model_check($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port unified instruction/data memory between two requesters: the CPU port and a DMA/loader port. The CPU port is driven by the multi-cycle control unit's fetch and load/store traffic. The DMA/loader port is used for program load and debug access. Each cycle the arbiter grants at most one access, drives the memory, and routes the one-cycle-latency read data back to the owner. It supports DMA bus locking for bursts and an optional starvation guard.

## Interface
- `MAX_CPU_STREAK`, default 4: consecutive CPU wins over a pending DMA request before DMA is forced (guard only); range 1..15.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 16: word address.
- `cpu_wdata` in 16: write data.
- `cpu_gnt` out 1: access accepted this cycle (combinational).
- `cpu_rvalid` out 1: read data valid (registered).
- `dma_req`, `dma_we`, `dma_addr[15:0]`, `dma_wdata[15:0]`, `dma_gnt`, `dma_rvalid`: same meanings as the CPU equivalents, for the DMA port.
- `dma_lock` in 1: hold ownership after the current grant.
- `rdata` out 16: `mem_rdata` passed through; qualified by `*_rvalid`.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data, valid the cycle after a read.
- `owner` out 2: current-cycle grant; 00 none, 01 CPU, 10 DMA.

## Operation
- Registered owner FSM with states S_IDLE, S_CPU, S_DMA and S_DMA_LOCK. The state records the previous cycle's grant.
- Grant decision is combinational, from the current state and the requests:
  - State S_DMA_LOCK and `dma_req`=1: DMA wins and the CPU is blocked.
  - Otherwise, only one requester active: that requester wins.
  - Otherwise, both requesters active: the CPU wins, except when the starvation guard fires.
- Next state:
  - DMA granted with `dma_lock`=1: S_DMA_LOCK.
  - DMA granted with `dma_lock`=0: S_DMA.
  - CPU granted: S_CPU.
  - No grant: S_IDLE.
  - In S_DMA_LOCK, if `dma_req` drops, the lock releases that cycle and normal arbitration applies.
- Memory drive:
  - The winner's `we`/`addr`/`wdata` are muxed to `mem_*`, with `mem_en`=1.
  - With no grant: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Read return:
  - The `*_rvalid` of the requester granted for a read (`we`=0) in cycle N is 1 in cycle N+1.
  - Write grants produce no rvalid.
- A losing requester holds `req`/`addr`/`we`/`wdata` stable until it sees `gnt`. The arbiter does not queue requests.

## Timing
- Grant latency is 0 cycles: `gnt` asserts in the request cycle when the requester wins.
- Read data latency is 1 cycle. Back-to-back accesses are allowed every cycle, and the two ports may alternate with no bubble.
- Reset values:
  - state S_IDLE, streak 0, `cpu_rvalid`=0, `dma_rvalid`=0.
  - With `reset_n` low and no requests, all combinational outputs are 0.
- Reset asserted mid-access: a pending rvalid is dropped, the lock is cleared and the streak is cleared.
- The CPU control unit stalls in any state where it requests and `cpu_gnt`=0.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - A 4-bit streak counter increments each cycle the CPU wins while `dma_req`=1.
  - It clears to 0 when DMA is granted or `dma_req`=0, and saturates at `MAX_CPU_STREAK`.
  - When streak equals `MAX_CPU_STREAK` and both requesters are active, DMA wins.
- `ARB_STARVE_GUARD_EN` undefined:
  - No counter is built.
  - Pure CPU priority outside the lock; DMA may starve indefinitely.

## Test plan
- Reset, then CPU-only reads at `cpu_addr`=0x0000..0x0003 on consecutive cycles -> `cpu_gnt`=1 each cycle, `mem_addr` follows, `cpu_rvalid`=1 one cycle later with `rdata`=memory contents; `dma_gnt`=0.
- DMA-only write of 0xBEEF to 0x0040 -> `dma_gnt`=1 and `mem_we`=1 in the same cycle, no `dma_rvalid`; a later CPU read of 0x0040 returns 0xBEEF.
- Both requesting continuously, guard defined, `MAX_CPU_STREAK`=4 -> grant pattern CPU,CPU,CPU,CPU,DMA repeating.
- Same stimulus, guard undefined -> CPU granted every cycle, `dma_gnt` never asserts.
- DMA granted with `dma_lock`=1 for 3 cycles while `cpu_req`=1 -> `dma_gnt`=1 for all 3 cycles; `cpu_gnt`=1 in the cycle after DMA drops `dma_req`.
- `reset_n` pulsed low the cycle after a granted CPU read -> `cpu_rvalid` stays 0, `owner`=00, next grant follows post-reset rules.
